// File: rtl/date_counter.sv
// Calendar day/month counter: midnight advance, time-zone day shifts, keypad edits
// and year carry/borrow pulses. Optional hold-to-repeat keys: `define KEY_REPEAT_EN.
module date_counter #(
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ClkDay,
  input  logic       ClkLeap,
  input  logic       DayOverPlus,
  input  logic       DayOverMinus,
  input  logic       KeyPlus,
  input  logic       KeyMinus,
  input  logic       EditMode,
  input  logic [1:0] screen,
  input  logic [2:0] EditPos,
  output logic [4:0] days,
  output logic [3:0] months,
  output logic       ClkYear,
  output logic       YearOverPlus,
  output logic       YearOverMinus
);

  typedef enum logic [2:0] {
    REQ_NONE, REQ_ADV, REQ_FWD, REQ_BACK, REQ_EPLUS, REQ_EMINUS
  } req_t;

  typedef struct packed {
    logic [4:0] d;
    logic [3:0] m;
    logic       yp;
    logic       ym;
  } res_t;

  function automatic logic [4:0] maxday(input logic [3:0] m, input logic leap);
    case (m)
      4'd4, 4'd6, 4'd9, 4'd11: maxday = 5'd30;
      4'd2:                    maxday = leap ? 5'd29 : 5'd28;
      default:                 maxday = 5'd31;
    endcase
  endfunction

  // One date operation; yp/ym flag a Dec->Jan or Jan->Dec crossing.
  function automatic res_t do_step(input req_t k, input logic [1:0] pos,
                                   input logic [4:0] d, input logic [3:0] m,
                                   input logic leap);
    res_t r;
    int   v, s, mx;
    r.d  = d;
    r.m  = m;
    r.yp = 1'b0;
    r.ym = 1'b0;
    case (k)
      REQ_ADV, REQ_FWD: begin
        if (d < maxday(m, leap)) r.d = d + 5'd1;
        else begin
          r.d = 5'd1;
          if (m == 4'd12) begin
            r.m  = 4'd1;
            r.yp = 1'b1;
          end else r.m = m + 4'd1;
        end
      end
      REQ_BACK: begin
        if (d > 5'd1) r.d = d - 5'd1;
        else begin
          if (m == 4'd1) begin
            r.m  = 4'd12;
            r.ym = 1'b1;
          end else r.m = m - 4'd1;
          r.d = maxday(r.m, leap);
        end
      end
      REQ_EPLUS, REQ_EMINUS: begin
        // pos[1] selects month field, pos[0] selects units (step 1) vs tens (step 10)
        s = pos[0] ? 1 : 10;
        if (pos[1]) begin
          v  = {28'd0, m};
          mx = 12;
        end else begin
          v  = {27'd0, d};
          mx = {27'd0, maxday(m, leap)};
        end
        if (k == REQ_EPLUS) begin
          v = v + s;
          if (v > mx) v = v - mx;
        end else begin
          v = v - s;
          if (v < 1) v = v + mx;
        end
        if (pos[1]) r.m = 4'(v);
        else        r.d = 5'(v);
      end
      default: ;
    endcase
    return r;
  endfunction

  req_t       r_pend, w_pend_n, w_req, w_app;
  logic [1:0] r_pos, w_pos_n, w_pos, w_app_pos;
  logic [4:0] r_days, w_days_n, w_max_n;
  logic [3:0] r_months;
  logic       r_clkyear, r_yop, r_yom;
  logic       w_edit_ok, w_key_req, w_fire, w_rep_sup;
  res_t       w_res;

  assign w_edit_ok = EditMode && (screen == 2'd1) && !EditPos[2];
  assign w_key_req = (w_req == REQ_EPLUS) || (w_req == REQ_EMINUS);

  always_comb begin
    w_req = REQ_NONE;
    w_pos = EditPos[1:0];
    if (ClkDay && !EditMode)                 w_req = REQ_ADV;
    else if (DayOverPlus && EditMode)        w_req = REQ_FWD;
    else if (DayOverMinus && EditMode)       w_req = REQ_BACK;
    else if (w_edit_ok && !KeyPlus)          w_req = REQ_EPLUS;
    else if (w_edit_ok && !KeyMinus)         w_req = REQ_EMINUS;
  end

`ifdef KEY_REPEAT_EN
  logic [31:0] r_hold;
  logic        r_rep;

  // After the first auto step the counter re-arms with the shorter period.
  assign w_fire    = w_key_req &&
                     (r_hold == (r_rep ? 32'(REPEAT_PERIOD - 1) : 32'(REPEAT_DELAY - 1)));
  assign w_rep_sup = r_rep;

  always_ff @(posedge clk) begin
    if (reset || !w_key_req) begin
      r_hold <= '0;
      r_rep  <= 1'b0;
    end else if (w_fire) begin
      r_hold <= '0;
      r_rep  <= 1'b1;
    end else begin
      r_hold <= r_hold + 32'd1;
    end
  end
`else
  assign w_fire    = 1'b0;
  assign w_rep_sup = 1'b0;
`endif

  always_comb begin
    w_pend_n  = r_pend;
    w_pos_n   = r_pos;
    w_app     = REQ_NONE;
    w_app_pos = r_pos;
    if (w_req != REQ_NONE) begin
      w_pend_n = w_req;
      w_pos_n  = w_pos;
      if (w_key_req && w_fire) begin
        w_app     = w_req;
        w_app_pos = w_pos;
      end
    end else begin
      w_pend_n = REQ_NONE;
      // a release after auto-repeat steps adds nothing
      if (!w_rep_sup) w_app = r_pend;
    end
    w_res    = do_step(w_app, w_app_pos, r_days, r_months, ClkLeap);
    w_max_n  = maxday(w_res.m, ClkLeap);
    w_days_n = (w_res.d > w_max_n) ? w_max_n : w_res.d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend    <= REQ_NONE;
      r_pos     <= 2'd0;
      r_days    <= 5'd1;
      r_months  <= 4'd1;
      r_clkyear <= 1'b0;
      r_yop     <= 1'b0;
      r_yom     <= 1'b0;
    end else begin
      r_pend    <= w_pend_n;
      r_pos     <= w_pos_n;
      r_days    <= w_days_n;
      r_months  <= w_res.m;
      r_clkyear <= w_res.yp && (w_app == REQ_ADV);
      r_yop     <= w_res.yp && (w_app == REQ_FWD);
      r_yom     <= w_res.ym;
    end
  end

  assign days          = r_days;
  assign months        = r_months;
  assign ClkYear       = r_clkyear;
  assign YearOverPlus  = r_yop;
  assign YearOverMinus = r_yom;

endmodule

// File: tb/tb_date_counter.sv
// Directed bench for date_counter: rollovers, time-zone shifts, edits, clamp, reset.
module tb_date_counter;
  logic       clk = 1'b0;
  logic       reset = 1'b0, ClkDay = 1'b0, ClkLeap = 1'b0;
  logic       DayOverPlus = 1'b0, DayOverMinus = 1'b0;
  logic       KeyPlus = 1'b1, KeyMinus = 1'b1, EditMode = 1'b0;
  logic [1:0] screen = 2'd0;
  logic [2:0] EditPos = 3'd0;
  logic [4:0] days;
  logic [3:0] months;
  logic       ClkYear, YearOverPlus, YearOverMinus;
  int         n_vec = 0, n_bad = 0;

  date_counter dut (
    .clk(clk), .reset(reset), .ClkDay(ClkDay), .ClkLeap(ClkLeap),
    .DayOverPlus(DayOverPlus), .DayOverMinus(DayOverMinus),
    .KeyPlus(KeyPlus), .KeyMinus(KeyMinus), .EditMode(EditMode),
    .screen(screen), .EditPos(EditPos), .days(days), .months(months),
    .ClkYear(ClkYear), .YearOverPlus(YearOverPlus), .YearOverMinus(YearOverMinus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_date(input string tag, input int d, input int m);
    chk({tag, ".day"}, 32'(days), 32'(d));
    chk({tag, ".mon"}, 32'(months), 32'(m));
  endtask

  task automatic chk_pulses(input string tag, input bit cy, input bit yp, input bit ym);
    chk({tag, ".ClkYear"}, 32'(ClkYear), 32'(cy));
    chk({tag, ".YOPlus"}, 32'(YearOverPlus), 32'(yp));
    chk({tag, ".YOMinus"}, 32'(YearOverMinus), 32'(ym));
  endtask

  task automatic press(input logic [2:0] pos, input bit plus, input int n);
    EditMode = 1'b1; screen = 2'd1; EditPos = pos;
    if (plus) KeyPlus = 1'b0; else KeyMinus = 1'b0;
    repeat (n) tick();
    KeyPlus = 1'b1; KeyMinus = 1'b1;
    tick();
  endtask

  task automatic pulse_tz(input bit fwd);
    if (fwd) DayOverPlus = 1'b1; else DayOverMinus = 1'b1;
    tick();
    DayOverPlus = 1'b0; DayOverMinus = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1; tick(); reset = 1'b0;
  endtask

  initial begin
    tick();
    do_reset();
    chk_date("reset", 1, 1);
    chk_pulses("reset", 0, 0, 0);

    press(3'd3, 0, 1);                        // month 1 -> 12
    chk_date("mon_minus_wrap", 1, 12);
    press(3'd1, 0, 1);                        // day 1 -> 31
    chk_date("day_minus_wrap", 31, 12);

    EditMode = 1'b0;
    ClkDay = 1'b1; tick(); ClkDay = 1'b0;
    chk_date("adv_latency", 31, 12);
    tick();
    chk_date("new_year", 1, 1);
    chk_pulses("new_year", 1, 0, 0);
    tick();
    chk_pulses("new_year_end", 0, 0, 0);

    press(3'd3, 1, 1); press(3'd3, 1, 1);     // month -> 3
    chk_date("set_mar", 1, 3);
    ClkLeap = 1'b1;
    pulse_tz(0);
    chk_date("mar1_back_leap", 29, 2);
    chk_pulses("mar1_back_leap", 0, 0, 0);
    ClkLeap = 1'b0; tick();
    chk_date("leap_drop_clamp", 28, 2);

    do_reset();
    pulse_tz(0);
    chk_date("jan1_back", 31, 12);
    chk_pulses("jan1_back", 0, 0, 1);
    tick();
    chk_pulses("jan1_back_end", 0, 0, 0);
    pulse_tz(1);
    chk_date("dec31_fwd", 1, 1);
    chk_pulses("dec31_fwd", 0, 1, 0);
    tick();
    chk_pulses("dec31_fwd_end", 0, 0, 0);

    press(3'd0, 1, 1); press(3'd0, 1, 1);     // 1 -> 11 -> 21
    repeat (4) press(3'd1, 1, 1);             // 21 -> 25
    chk_date("set_25", 25, 1);
    EditMode = 1'b1; screen = 2'd1; EditPos = 3'd0; KeyPlus = 1'b0;
    repeat (5) tick();
    chk_date("hold_no_step", 25, 1);
    KeyPlus = 1'b1; tick();
    chk_date("release_step", 4, 1);
    tick();
    chk_date("single_step", 4, 1);
    press(3'd3, 0, 3);
    chk_date("mon_minus_jan", 4, 12);
    press(3'd2, 1, 1);                        // 12+10 = 22 -> 10
    chk_date("mon_tens_wrap", 4, 10);

    repeat (5) press(3'd3, 1, 1);             // 10 -> 3
    repeat (4) press(3'd1, 0, 1);             // 4 -> 31
    chk_date("set_31_3", 31, 3);
    press(3'd3, 1, 1);
    chk_date("mon_edit_clamp", 30, 4);

    EditMode = 1'b0; EditPos = 3'd1;
    ClkDay = 1'b1; KeyPlus = 1'b0; tick();
    ClkDay = 1'b0; KeyPlus = 1'b1; tick();
    chk_date("adv_over_key", 1, 5);
    chk_pulses("adv_over_key", 0, 0, 0);

    EditMode = 1'b1; ClkDay = 1'b1; tick(); ClkDay = 1'b0; tick();
    chk_date("clkday_in_edit", 1, 5);
    EditMode = 1'b0; pulse_tz(1);
    chk_date("tz_in_normal", 1, 5);
    EditMode = 1'b1; screen = 2'd0; EditPos = 3'd1;
    KeyPlus = 1'b0; tick(); KeyPlus = 1'b1; tick();
    chk_date("wrong_screen", 1, 5);

    do_reset();
    EditMode = 1'b1; pulse_tz(0); tick();
    chk_date("pre_reset_31_12", 31, 12);
    EditMode = 1'b0;
    ClkDay = 1'b1; tick(); ClkDay = 1'b0;
    reset = 1'b1; tick(); reset = 1'b0;
    chk_date("reset_drop", 1, 1);
    chk_pulses("reset_drop", 0, 0, 0);
    tick();
    chk_date("reset_drop_after", 1, 1);
    chk_pulses("reset_drop_after", 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
